// File: rtl/cumulative_histogram_pkg.sv
// Shared defaults and state encoding for the cumulative histogram block
// and its companion dual-port RAM.
package cumulative_histogram_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_THRESH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/true_dpram_sclk.sv
// Single-clock true dual-port RAM with registered read data on both ports.
// Each port returns old data on read-during-write; a same-address dual write keeps port b's data.
module true_dpram_sclk
    import cumulative_histogram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_a,
    input  logic              we_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Port b's write is issued last so it wins an address collision.
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        if (we_a) begin
            mem[addr_a] <= data_a;
        end
        if (we_b) begin
            mem[addr_b] <= data_b;
        end
    end

endmodule

// File: rtl/cumulative_histogram.sv
// Builds the cumulative histogram of an external histogram RAM, then rereads it
// to find the median bin. Both RAMs sit outside this block.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for iStart
// ST_ACCUM  | read h[k], accumulate, write running sum to cumulative RAM
// ST_THRESH | reread h[k], rebuild running sum, find first 2*r(k) >= total
// ST_DONE   | results valid, oDone high until iStart/iRestart/iReset
module cumulative_histogram
    import cumulative_histogram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic              iRestart,
    input  logic [DATA_W-1:0] iQInHist,
    output logic [ADDR_W-1:0] oAddrInHist,
    output logic [DATA_W-1:0] oDataOutCumH,
    output logic [ADDR_W-1:0] oAddrOutCumH,
    output logic              oWE,
    output logic [ADDR_W-1:0] oThresh50,
    output logic              oDone,
    output logic [DATA_W-1:0] oMaxValue
);

    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    state_t            state;
    logic              rd_act;
    logic              q_vld;
    logic [ADDR_W-1:0] q_idx;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] run_sum;
    logic              found;
    logic              fin;
    logic [ADDR_W-1:0] thr_k;

    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] run_next;
    logic              half_hit;

    assign acc_next = acc + iQInHist;
    assign run_next = run_sum + iQInHist;
    // One extra bit so doubling the running sum can never wrap in the compare.
    assign half_hit = {run_next, 1'b0} >= {1'b0, oMaxValue};

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state        <= ST_IDLE;
            oAddrInHist  <= '0;
            oDataOutCumH <= '0;
            oAddrOutCumH <= '0;
            oWE          <= 1'b0;
            oThresh50    <= '0;
            oDone        <= 1'b0;
            oMaxValue    <= '0;
            rd_act       <= 1'b0;
            q_vld        <= 1'b0;
            q_idx        <= '0;
            acc          <= '0;
            run_sum      <= '0;
            found        <= 1'b0;
            fin          <= 1'b0;
            thr_k        <= '0;
        end else if (iRestart) begin
            state  <= ST_IDLE;
            oWE    <= 1'b0;
            oDone  <= 1'b0;
            rd_act <= 1'b0;
            q_vld  <= 1'b0;
            fin    <= 1'b0;
        end else begin
            // Read pipeline: the bin index travels alongside the RAM's one-cycle latency.
            q_vld <= rd_act;
            q_idx <= oAddrInHist;
            if (rd_act) begin
                if (oAddrInHist == LAST_BIN) begin
                    rd_act <= 1'b0;
                end else begin
                    oAddrInHist <= oAddrInHist + 1'b1;
                end
            end

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (iStart) begin
                        state       <= ST_ACCUM;
                        acc         <= '0;
                        oAddrInHist <= '0;
                        rd_act      <= 1'b1;
                        q_vld       <= 1'b0;
                        oDone       <= 1'b0;
                    end
                end

                ST_ACCUM: begin
                    oWE <= q_vld;
                    if (q_vld) begin
                        acc          <= acc_next;
                        oDataOutCumH <= acc_next;
                        oAddrOutCumH <= q_idx;
                    end
                    if (oWE && (oAddrOutCumH == LAST_BIN)) begin
                        state       <= ST_THRESH;
                        oMaxValue   <= acc;
                        oWE         <= 1'b0;
                        oAddrInHist <= '0;
                        rd_act      <= 1'b1;
                        run_sum     <= '0;
                        found       <= 1'b0;
                        fin         <= 1'b0;
                    end
                end

                ST_THRESH: begin
                    if (q_vld) begin
                        run_sum <= run_next;
                        if (!found && half_hit) begin
                            found <= 1'b1;
                            thr_k <= q_idx;
                        end
                        if (q_idx == LAST_BIN) begin
                            fin <= 1'b1;
                        end
                    end
                    if (fin) begin
                        state     <= ST_DONE;
                        oDone     <= 1'b1;
                        oThresh50 <= thr_k;
                        fin       <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cumulative_histogram.sv
// Bench for cumulative_histogram with both RAMs modelled by true_dpram_sclk;
// expected sums and median come from a plain-arithmetic model of the histogram.
module tb_cumulative_histogram;
    import cumulative_histogram_pkg::*;

    localparam int DW  = 20;
    localparam int AW  = 8;
    localparam int N   = 256;
    localparam int LAT = 2 * N + 4;

    logic          iClk;
    logic          iReset;
    logic          iStart;
    logic          iRestart;
    logic [DW-1:0] iQInHist;
    logic [AW-1:0] oAddrInHist;
    logic [DW-1:0] oDataOutCumH;
    logic [AW-1:0] oAddrOutCumH;
    logic          oWE;
    logic [AW-1:0] oThresh50;
    logic          oDone;
    logic [DW-1:0] oMaxValue;

    logic [DW-1:0] hl_data;
    logic [AW-1:0] hl_addr;
    logic          hl_we;
    logic [DW-1:0] hist_qb;
    logic [AW-1:0] cr_addr;
    logic [DW-1:0] cr_q;
    logic [DW-1:0] cum_qa;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] h       [N];
    logic [DW-1:0] exp_cum [N];
    logic [DW-1:0] exp_max;
    int            exp_thr;
    bit            mon_en = 0;
    bit            idle_chk = 0;
    int            wr_cnt = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    cumulative_histogram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iStart       (iStart),
        .iRestart     (iRestart),
        .iQInHist     (iQInHist),
        .oAddrInHist  (oAddrInHist),
        .oDataOutCumH (oDataOutCumH),
        .oAddrOutCumH (oAddrOutCumH),
        .oWE          (oWE),
        .oThresh50    (oThresh50),
        .oDone        (oDone),
        .oMaxValue    (oMaxValue)
    );

    true_dpram_sclk #(.DATA_W(DW), .ADDR_W(AW)) u_hist (
        .clk    (iClk),
        .data_a ('0),
        .data_b (hl_data),
        .addr_a (oAddrInHist),
        .addr_b (hl_addr),
        .we_a   (1'b0),
        .we_b   (hl_we),
        .q_a    (iQInHist),
        .q_b    (hist_qb)
    );

    true_dpram_sclk #(.DATA_W(DW), .ADDR_W(AW)) u_cum (
        .clk    (iClk),
        .data_a (oDataOutCumH),
        .data_b ('0),
        .addr_a (oAddrOutCumH),
        .addr_b (cr_addr),
        .we_a   (oWE),
        .we_b   (1'b0),
        .q_a    (cum_qa),
        .q_b    (cr_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void build_model();
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s = s + h[k];
            exp_cum[k] = s;
        end
        exp_max = s;
        exp_thr = -1;
        for (int k = 0; k < N; k++) begin
            if (exp_thr < 0 && 2 * int'(exp_cum[k]) >= int'(exp_max)) exp_thr = k;
        end
    endfunction

    // Advance one clock, sample outputs 2 time units later and compare the write stream.
    task automatic tick();
        @(posedge iClk);
        #2;
        if (mon_en) begin
            if (oWE === 1'b1) begin
                if (wr_cnt < N) begin
                    check("wr_addr", 32'(oAddrOutCumH), wr_cnt);
                    check("wr_data", 32'(oDataOutCumH), 32'(exp_cum[wr_cnt]));
                end else begin
                    check("wr_overrun", wr_cnt, N - 1);
                end
                wr_cnt++;
            end
        end else if (idle_chk) begin
            check("we_idle", 32'(oWE), 0);
        end
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) begin
            hl_we   = 1'b1;
            hl_addr = AW'(i);
            hl_data = h[i];
            tick();
        end
        hl_we = 1'b0;
    endtask

    task automatic rb(input int a, input logic [31:0] lit);
        cr_addr = AW'(a);
        tick();
        check("cum_ram_model", 32'(cr_q), 32'(exp_cum[a]));
        check("cum_ram_lit", 32'(cr_q), lit);
    endtask

    task automatic run(input bit busy);
        int cyc;
        build_model();
        wr_cnt = 0;
        mon_en = 1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        cyc = 0;
        while (oDone !== 1'b1 && cyc < LAT + 50) begin
            iStart = busy && (cyc == 50 || cyc == 300);
            tick();
            cyc++;
        end
        iStart = 1'b0;
        check("latency", cyc, LAT);
        check("wr_count", wr_cnt, N);
        check("max_model", 32'(oMaxValue), 32'(exp_max));
        check("thr_model", 32'(oThresh50), exp_thr);
        mon_en = 0;
    endtask

    initial begin
        iReset   = 1'b1;
        iRestart = 1'b0;
        iStart   = 1'b0;
        hl_we    = 1'b0;
        hl_addr  = '0;
        hl_data  = '0;
        cr_addr  = '0;
        repeat (3) tick();
        check("rst_addr_in", 32'(oAddrInHist), 0);
        check("rst_data_out", 32'(oDataOutCumH), 0);
        check("rst_addr_out", 32'(oAddrOutCumH), 0);
        check("rst_we", 32'(oWE), 0);
        check("rst_thr", 32'(oThresh50), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_max", 32'(oMaxValue), 0);
        iReset = 1'b0;
        idle_chk = 1;
        tick();

        // all bins zero
        for (int i = 0; i < N; i++) h[i] = '0;
        load();
        run(0);
        check("zero_max_lit", 32'(oMaxValue), 0);
        check("zero_thr_lit", 32'(oThresh50), 0);
        rb(128, 0);

        // all bins one, with iStart pulses while busy
        for (int i = 0; i < N; i++) h[i] = DW'(1);
        load();
        run(1);
        check("ones_max_lit", 32'(oMaxValue), 256);
        check("ones_thr_lit", 32'(oThresh50), 127);
        rb(0, 1);
        rb(99, 100);
        rb(255, 256);

        // single spike at bin 200
        for (int i = 0; i < N; i++) h[i] = '0;
        h[200] = DW'(1000);
        load();
        run(0);
        check("spike_max_lit", 32'(oMaxValue), 1000);
        check("spike_thr_lit", 32'(oThresh50), 200);
        rb(199, 0);
        rb(200, 1000);
        rb(255, 1000);

        // mass at both ends
        for (int i = 0; i < N; i++) h[i] = '0;
        h[0]   = DW'(500);
        h[255] = DW'(500);
        load();
        run(0);
        check("ends_max_lit", 32'(oMaxValue), 1000);
        check("ends_thr_lit", 32'(oThresh50), 0);
        rb(254, 500);
        rb(255, 1000);

        // iRestart and iStart together while DONE: restart wins
        iRestart = 1'b1;
        iStart   = 1'b1;
        tick();
        iRestart = 1'b0;
        iStart   = 1'b0;
        check("rs_done_drop", 32'(oDone), 0);
        check("rs_keep_max", 32'(oMaxValue), 1000);
        repeat (6) begin
            tick();
            check("rs_we_low", 32'(oWE), 0);
            check("rs_done_low", 32'(oDone), 0);
        end

        // sums wrap: 256 * 4096 = 2**20; restart at cycle 100 of ACCUM first
        for (int i = 0; i < N; i++) h[i] = DW'(4096);
        load();
        build_model();
        wr_cnt = 0;
        mon_en = 1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (100) tick();
        iRestart = 1'b1;
        tick();
        iRestart = 1'b0;
        mon_en = 0;
        check("restart_we", 32'(oWE), 0);
        check("restart_done", 32'(oDone), 0);
        check("restart_keep_max", 32'(oMaxValue), 1000);
        check("restart_keep_thr", 32'(oThresh50), 0);
        repeat (5) begin
            tick();
            check("restart_done_low", 32'(oDone), 0);
        end
        run(0);
        check("wrap_max_lit", 32'(oMaxValue), 0);
        check("wrap_thr_lit", 32'(oThresh50), 0);
        rb(127, 524288);
        rb(254, 32'hFF000);
        rb(255, 0);

        // ramp h[k] = k; reset (with restart and start) in the middle of THRESH first
        for (int i = 0; i < N; i++) h[i] = DW'(i);
        load();
        build_model();
        wr_cnt = 0;
        mon_en = 1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (349) tick();
        iReset   = 1'b1;
        iRestart = 1'b1;
        iStart   = 1'b1;
        tick();
        iReset   = 1'b0;
        iRestart = 1'b0;
        iStart   = 1'b0;
        check("midrst_wr_count", wr_cnt, N);
        mon_en = 0;
        check("midrst_addr_in", 32'(oAddrInHist), 0);
        check("midrst_data_out", 32'(oDataOutCumH), 0);
        check("midrst_addr_out", 32'(oAddrOutCumH), 0);
        check("midrst_we", 32'(oWE), 0);
        check("midrst_thr", 32'(oThresh50), 0);
        check("midrst_done", 32'(oDone), 0);
        check("midrst_max", 32'(oMaxValue), 0);
        repeat (4) begin
            tick();
            check("midrst_idle_addr", 32'(oAddrInHist), 0);
        end
        run(1);
        check("ramp_max_lit", 32'(oMaxValue), 32640);
        check("ramp_thr_lit", 32'(oThresh50), 181);
        rb(180, 16290);
        rb(255, 32640);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cumulative_histogram.md
CUMULATIVE_HISTOGRAM -- requirements
Module: cumulative_histogram

Interface
REQ-001 Parameter DATA_W, default 20: bin count and cumulative sum width.
REQ-002 Parameter ADDR_W, default 8: bin address width; bin count N = 2**ADDR_W (256).
REQ-003 iClk  in  1  single clock; all logic is rising-edge triggered.
REQ-004 iReset  in  1  reset; synchronous and active-high.
REQ-005 iStart  in  1  one-cycle pulse that begins a computation.
REQ-006 iRestart  in  1  synchronous abort; returns the block to IDLE.
REQ-007 iQInHist  in  DATA_W  input-histogram RAM read data; valid one cycle after oAddrInHist.
REQ-008 oAddrInHist  out  ADDR_W  input-histogram RAM read address.
REQ-009 oDataOutCumH  out  DATA_W  cumulative-histogram RAM write data.
REQ-010 oAddrOutCumH  out  ADDR_W  cumulative-histogram RAM write address.
REQ-011 oWE  out  1  cumulative-histogram RAM write enable.
REQ-012 oThresh50  out  ADDR_W  median (50 %) threshold bin.
REQ-013 oDone  out  1  result-valid level.
REQ-014 oMaxValue  out  DATA_W  total count, i.e. the cumulative value of bin N-1.

Function
REQ-015 FSM states: IDLE, ACCUM, THRESH, DONE; every output is registered.
REQ-016 IDLE or DONE + iStart=1 -> ACCUM: clear accumulator and address counter; drop oDone.
REQ-017 iStart in ACCUM or THRESH is ignored.
REQ-018 ACCUM address issue: oAddrInHist = 0..N-1 ascending, one per cycle.
REQ-019 ACCUM sum: on each valid iQInHist, acc <= acc + h[k].
REQ-020 ACCUM write: the cycle after each sum, oWE=1, oAddrOutCumH=k, oDataOutCumH=sum(h[0..k]).
REQ-021 oWE is high for exactly N cycles per run, addresses 0..N-1 strictly ascending, and low in every other state.
REQ-022 ACCUM end: after the write of bin N-1, latch oMaxValue <= acc and go to THRESH.
REQ-023 THRESH rereads h[0..N-1] with the same one-cycle latency and rebuilds the running sum r.
REQ-024 THRESH result: oThresh50 = smallest k with 2*r(k) >= oMaxValue; the compare uses DATA_W+1 bits.
REQ-025 After all N bins are reread, THRESH goes to DONE.
REQ-026 DONE holds oDone=1, oThresh50 and oMaxValue until iStart, iRestart or iReset.
REQ-027 Sums wrap modulo 2**DATA_W; there is no saturation and no overflow flag.
REQ-028 All bins zero -> oMaxValue=0, oThresh50=0.
REQ-029 iRestart in any state -> IDLE next cycle: oWE=0, oDone=0; oThresh50 and oMaxValue keep their old values.
REQ-030 iRestart and iStart in the same cycle: iRestart wins.
REQ-031 Run latency from the iStart pulse to oDone rising is 2N+4 cycles, fixed.

Reset
REQ-032 iReset=1 forces IDLE and clears oAddrInHist, oDataOutCumH, oAddrOutCumH, oWE, oThresh50, oDone, oMaxValue, the accumulator and the counters.
REQ-033 iReset has priority over iRestart and iStart.
REQ-034 After iReset deasserts the block waits in IDLE for iStart.

Structure
REQ-035 Shared package holds DATA_W and ADDR_W defaults and the state enumeration.
REQ-036 The block has no sub-modules; both RAMs sit outside it.
REQ-037 Companion RAM true_dpram_sclk: two ports (a, b), each with data, addr, we and q.
REQ-038 true_dpram_sclk read/write: q is registered, latency 1; a write updates the array on the clock edge.
REQ-039 true_dpram_sclk read-during-write on the same port returns the old data; simultaneous writes to the same address from a and b leave port b's data.

Verification
REQ-040 All bins = 1 -> cum[k]=k+1, oMaxValue=256, oThresh50=127.
REQ-041 Only h[200]=1000 -> cum[0..199]=0, cum[200..255]=1000, oMaxValue=1000, oThresh50=200.
REQ-042 All bins zero -> all cum=0, oMaxValue=0, oThresh50=0, oDone after 2N+4 cycles.
REQ-043 h[0]=h[255]=500, rest 0 -> cum[254]=500, oMaxValue=1000, oThresh50=0.
REQ-044 iRestart at cycle 100 of ACCUM -> oWE=0 next cycle, IDLE, oDone stays 0; a new iStart then gives correct results.
REQ-045 iReset mid-THRESH -> all outputs 0 next cycle; iStart pulsed while busy is ignored, shown by oWE staying N cycles long.
